// File: rtl/stopwatch_lap.sv
// Stopwatch with ms/sec/min/hr cascade, start/stop/clear control and a lap ring buffer.
// The displayed time is registered and shows either the live count or one stored lap.
module stopwatch_lap #(
  parameter int LAP_DEPTH = 4,
  parameter int HR_MAX    = 23,
  parameter bit WRAP      = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ms_pulse,
  input  logic       i_set,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_right,
  input  logic       i_left,
  output logic [9:0] o_ms,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hr,
  output logic       o_running,
  output logic       o_overflow,
  output logic [3:0] o_lap_cnt,
  output logic [3:0] o_view
);

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [9:0] ms;
  } time_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_HALT} state_e;

  localparam logic [3:0] DEPTH     = 4'(LAP_DEPTH);
  localparam logic [3:0] DEPTH_M1  = 4'(LAP_DEPTH - 1);
  localparam logic [4:0] HR_TOP    = 5'(HR_MAX);

  state_e     state_q, state_d;
  time_t      cnt_q, cnt_d, cnt_inc;
  time_t      disp_q, disp_d, sel_lap;
  time_t      lap_q [16];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] lap_cnt_q, lap_cnt_d;
  logic [3:0] view_q, view_d;
  logic       running_q, overflow_q;
  logic       at_max, count, push, clear;
  logic [4:0] sel_sum;
  logic [3:0] sel_idx;

  // Full cascade increment; at_max flags the last representable time.
  always_comb begin
    cnt_inc = cnt_q;
    at_max  = 1'b0;
    if (cnt_q.ms != 10'd999) begin
      cnt_inc.ms = cnt_q.ms + 10'd1;
    end else begin
      cnt_inc.ms = '0;
      if (cnt_q.sec != 6'd59) begin
        cnt_inc.sec = cnt_q.sec + 6'd1;
      end else begin
        cnt_inc.sec = '0;
        if (cnt_q.min != 6'd59) begin
          cnt_inc.min = cnt_q.min + 6'd1;
        end else begin
          cnt_inc.min = '0;
          if (cnt_q.hr != HR_TOP) begin
            cnt_inc.hr = cnt_q.hr + 5'd1;
          end else begin
            cnt_inc.hr = '0;
            at_max     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    count   = (state_q == S_RUN) && i_ms_pulse;
    push    = (state_q == S_RUN) && i_up;
    if (count && !(at_max && !WRAP)) cnt_d = cnt_inc;
    unique case (state_q)
      S_IDLE:  if (i_set) state_d = S_RUN;
      S_RUN: begin
        // Saturation wins over a coincident stop so the overflow is never lost.
        if (count && at_max && !WRAP) state_d = S_HALT;
        else if (i_set)               state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (i_set)       state_d = S_RUN;
        else if (i_down) clear   = 1'b1;
      end
      S_HALT:  if (i_down) clear = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    lap_cnt_d = lap_cnt_q;
    view_d    = view_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == DEPTH_M1) ? 4'd0 : wr_ptr_q + 4'd1;
      if (lap_cnt_q != DEPTH) lap_cnt_d = lap_cnt_q + 4'd1;
    end
    if (i_left && !i_right && (view_q < lap_cnt_q))    view_d = view_q + 4'd1;
    else if (i_right && !i_left && (view_q != 4'd0))   view_d = view_q - 4'd1;
    if (clear) begin
      wr_ptr_d  = '0;
      lap_cnt_d = '0;
      view_d    = '0;
    end
  end

  // k-th most recent lap sits k slots behind the next write pointer; bypass a same-cycle push.
  always_comb begin
    sel_sum = {1'b0, wr_ptr_d} + {1'b0, DEPTH} - {1'b0, view_d};
    if (sel_sum >= {1'b0, DEPTH}) sel_sum = sel_sum - {1'b0, DEPTH};
    sel_idx = sel_sum[3:0];
    sel_lap = (push && (sel_idx == wr_ptr_q)) ? cnt_q : lap_q[sel_idx];
    disp_d  = (view_d == 4'd0) ? cnt_d : sel_lap;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      disp_q     <= '0;
      wr_ptr_q   <= '0;
      lap_cnt_q  <= '0;
      view_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      wr_ptr_q   <= wr_ptr_d;
      lap_cnt_q  <= lap_cnt_d;
      view_q     <= view_d;
      running_q  <= (state_d == S_RUN);
      overflow_q <= (state_d == S_HALT);
    end
  end

  // Lap payload needs no reset: validity is tracked solely by lap_cnt_q.
  always_ff @(posedge i_clk) begin
    if (i_rstn && push) lap_q[wr_ptr_q] <= cnt_q;
  end

  assign o_ms       = disp_q.ms;
  assign o_sec      = disp_q.sec;
  assign o_min      = disp_q.min;
  assign o_hr       = disp_q.hr;
  assign o_running  = running_q;
  assign o_overflow = overflow_q;
  assign o_lap_cnt  = lap_cnt_q;
  assign o_view     = view_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: default build plus HR_MAX=1 saturate and wrap builds.
module tb_stopwatch_lap;
  logic clk = 1'b0, rstn = 1'b0;
  logic ms_pulse = 1'b0, set = 1'b0, up = 1'b0, down = 1'b0, right = 1'b0, left = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] ms0, ms1, ms2;
  logic [5:0] sec0, sec1, sec2, min0, min1, min2;
  logic [4:0] hr0, hr1, hr2;
  logic       run0, run1, run2, ovf0, ovf1, ovf2;
  logic [3:0] lc0, lc1, lc2, vw0, vw1, vw2;

  int n_vec = 0, n_err = 0;

  localparam logic [5:0] B_MS = 6'b100000, B_SET = 6'b010000, B_UP = 6'b001000;
  localparam logic [5:0] B_DOWN = 6'b000100, B_RIGHT = 6'b000010, B_LEFT = 6'b000001;

  stopwatch_lap dut0 (.i_clk(clk), .i_rstn(rstn), .i_ms_pulse(ms_pulse), .i_set(set), .i_up(up),
    .i_down(down), .i_right(right), .i_left(left), .o_ms(ms0), .o_sec(sec0), .o_min(min0),
    .o_hr(hr0), .o_running(run0), .o_overflow(ovf0), .o_lap_cnt(lc0), .o_view(vw0));

  stopwatch_lap #(.LAP_DEPTH(4), .HR_MAX(1), .WRAP(1'b0)) dut1 (.i_clk(clk), .i_rstn(rstn),
    .i_ms_pulse(ms_pulse), .i_set(set), .i_up(up), .i_down(down), .i_right(right), .i_left(left),
    .o_ms(ms1), .o_sec(sec1), .o_min(min1), .o_hr(hr1), .o_running(run1), .o_overflow(ovf1),
    .o_lap_cnt(lc1), .o_view(vw1));

  stopwatch_lap #(.LAP_DEPTH(4), .HR_MAX(1), .WRAP(1'b1)) dut2 (.i_clk(clk), .i_rstn(rstn),
    .i_ms_pulse(ms_pulse), .i_set(set), .i_up(up), .i_down(down), .i_right(right), .i_left(left),
    .o_ms(ms2), .o_sec(sec2), .o_min(min2), .o_hr(hr2), .o_running(run2), .o_overflow(ovf2),
    .o_lap_cnt(lc2), .o_view(vw2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int inst, input int h, input int m,
                          input int s, input int ms);
    logic [31:0] gh, gm, gs, gms;
    case (inst)
      0:       begin gh = 32'(hr0); gm = 32'(min0); gs = 32'(sec0); gms = 32'(ms0); end
      1:       begin gh = 32'(hr1); gm = 32'(min1); gs = 32'(sec1); gms = 32'(ms1); end
      default: begin gh = 32'(hr2); gm = 32'(min2); gs = 32'(sec2); gms = 32'(ms2); end
    endcase
    chk({tag, ".hr"}, gh, h);
    chk({tag, ".min"}, gm, m);
    chk({tag, ".sec"}, gs, s);
    chk({tag, ".ms"}, gms, ms);
  endtask

  // Drive a one-cycle button pattern; outputs are sampled on the following falling edge.
  task automatic apply(input logic [5:0] b);
    {ms_pulse, set, up, down, right, left} = b;
    @(negedge clk);
    {ms_pulse, set, up, down, right, left} = '0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) apply(B_MS);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    apply('0);
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    rstn = 1'b0;
    apply('0);
    apply('0);
    chk_time("rst", 0, 0, 0, 0, 0);
    chk("rst.run", 32'(run0), 0);
    chk("rst.ovf", 32'(ovf0), 0);
    chk("rst.lapcnt", 32'(lc0), 0);
    chk("rst.view", 32'(vw0), 0);
    rstn = 1'b1;

    // start, 1500 ms, stop
    apply(B_SET);
    chk("start.run", 32'(run0), 1);
    pulses(1500);
    apply(B_SET);
    chk_time("t1500", 0, 0, 0, 1, 500);
    chk("t1500.run", 32'(run0), 0);
    apply(B_SET | B_DOWN);
    chk("setdown.run", 32'(run0), 1);
    chk_time("setdown", 0, 0, 0, 1, 500);
    apply(B_DOWN);
    chk("downrun.run", 32'(run0), 1);
    apply(B_SET | B_MS);
    chk_time("stopcnt", 0, 0, 0, 1, 501);
    chk("stopcnt.run", 32'(run0), 0);
    apply(B_SET | B_MS);
    chk_time("startnocnt", 0, 0, 0, 1, 501);
    chk("startnocnt.run", 32'(run0), 1);
    apply(B_SET);
    apply(B_DOWN);
    chk_time("clear", 0, 0, 0, 0, 0);
    apply(B_MS);
    chk_time("idlepulse", 0, 0, 0, 0, 0);

    // six laps into a depth-4 ring
    apply(B_SET);
    for (int k = 0; k < 6; k++) begin
      pulses(100);
      apply(B_UP);
    end
    chk("laps.cnt", 32'(lc0), 4);
    apply(B_LEFT);
    chk("v1.view", 32'(vw0), 1);
    chk("v1.ms", 32'(ms0), 600);
    apply(B_LEFT); apply(B_LEFT); apply(B_LEFT);
    chk("v4.view", 32'(vw0), 4);
    chk("v4.ms", 32'(ms0), 300);
    apply(B_LEFT);
    chk("v4sat.view", 32'(vw0), 4);
    chk("v4sat.ms", 32'(ms0), 300);
    apply(B_RIGHT);
    chk("v3.ms", 32'(ms0), 400);
    apply(B_LEFT | B_RIGHT);
    chk("vboth.view", 32'(vw0), 3);
    pulses(5);
    chk("vcount.ms", 32'(ms0), 400);
    apply(B_RIGHT); apply(B_RIGHT); apply(B_RIGHT); apply(B_RIGHT);
    chk("v0.view", 32'(vw0), 0);
    chk_time("v0live", 0, 0, 0, 0, 605);

    // capture coincident with a count pulse
    apply(B_SET);
    apply(B_DOWN);
    chk("clr.lapcnt", 32'(lc0), 0);
    apply(B_SET);
    pulses(41);
    apply(B_MS | B_UP);
    chk("cap.live", 32'(ms0), 42);
    chk("cap.lapcnt", 32'(lc0), 1);
    apply(B_LEFT);
    chk("cap.lap", 32'(ms0), 41);

    // reset mid-run
    do_reset();
    apply(B_SET);
    pulses(1000); apply(B_UP);
    pulses(1000); apply(B_UP);
    pulses(1210);
    chk_time("pre_rst", 0, 0, 0, 3, 210);
    chk("pre_rst.lapcnt", 32'(lc0), 2);
    rstn = 1'b0;
    apply(B_MS | B_UP);
    chk_time("midrst", 0, 0, 0, 0, 0);
    chk("midrst.lapcnt", 32'(lc0), 0);
    chk("midrst.run", 32'(run0), 0);
    rstn = 1'b1;
    apply(B_MS);
    chk_time("postrst", 0, 0, 0, 0, 0);

    // cascade carries on the default build
    apply(B_SET);
    force dut0.cnt_q = {5'd0, 6'd0, 6'd59, 10'd999};
    apply(B_MS);
    chk_time("mincarry", 0, 0, 1, 0, 0);
    force dut0.cnt_q = {5'd23, 6'd59, 6'd59, 10'd999};
    apply(B_MS);
    chk_time("daywrap", 0, 0, 0, 0, 0);
    chk("daywrap.run", 32'(run0), 1);
    release dut0.cnt_q;

    // HR_MAX=1: saturate (dut1) vs wrap (dut2)
    do_reset();
    apply(B_SET);
    force dut1.cnt_q = {5'd1, 6'd59, 6'd59, 10'd999};
    force dut2.cnt_q = {5'd1, 6'd59, 6'd59, 10'd999};
    apply(B_MS);
    chk_time("sat", 1, 1, 59, 59, 999);
    chk("sat.ovf", 32'(ovf1), 1);
    chk("sat.run", 32'(run1), 0);
    chk_time("wrap", 2, 0, 0, 0, 0);
    chk("wrap.run", 32'(run2), 1);
    release dut1.cnt_q;
    release dut2.cnt_q;
    apply(B_SET);
    chk("halt_set.ovf", 32'(ovf1), 1);
    chk("halt_set.run", 32'(run1), 0);
    apply(B_DOWN);
    chk_time("halt_clr", 1, 0, 0, 0, 0);
    chk("halt_clr.ovf", 32'(ovf1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_lap.md
STOPWATCH_LAP -- requirements
Module: stopwatch_lap

Interface
REQ-001 SHALL have parameter LAP_DEPTH, default 4, number of stored lap times (range 1..15).
REQ-002 SHALL have parameter HR_MAX, default 23, last hour value before rollover (range 1..31).
REQ-003 SHALL have parameter WRAP, default 1, rollover mode: 1 = wrap to zero, 0 = saturate and halt.
REQ-004 SHALL have i_clk, input, 1, single clock for all logic.
REQ-005 SHALL have i_rstn, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have i_ms_pulse, input, 1, one-cycle pulse per elapsed millisecond.
REQ-007 SHALL have i_set, input, 1, start/stop toggle; i_up, input, 1, lap capture; i_down, input, 1, clear; i_right/i_left, input, 1 each, view newer/older. All buttons are single-cycle pulses.
REQ-008 SHALL have o_ms [9:0], o_sec [5:0], o_min [5:0], o_hr [4:0], outputs, displayed time.
REQ-009 SHALL have o_running, output, 1, high in RUN state.
REQ-010 SHALL have o_overflow, output, 1, high in HALT state.
REQ-011 SHALL have o_lap_cnt [3:0], output, number of valid laps stored; o_view [3:0], output, 0 = live, k = k-th most recent lap.

Function
REQ-012 SHALL implement states IDLE (stopped, zero), RUN, PAUSE (stopped, nonzero), HALT (saturated).
REQ-013 SHALL transition: IDLE/PAUSE --i_set--> RUN; RUN --i_set--> PAUSE; PAUSE --i_down--> IDLE; HALT --i_down--> IDLE; i_set in HALT ignored.
REQ-014 SHALL increment the time counter only in RUN on a cycle with i_ms_pulse=1; the new value appears on outputs the following cycle.
REQ-015 SHALL not count an i_ms_pulse coincident with the i_set that enters RUN; SHALL count one coincident with the i_set that leaves RUN.
REQ-016 SHALL cascade: ms 0..999, carry -> sec 0..59, carry -> min 0..59, carry -> hr 0..HR_MAX.
REQ-017 SHALL, at HR_MAX:59:59.999 plus one pulse, go to all-zero when WRAP=1 (stay RUN), or hold HR_MAX:59:59.999 and enter HALT when WRAP=0.
REQ-018 SHALL, on i_up in RUN, push the current registered time (pre-increment if i_ms_pulse coincides) into a lap ring buffer; i_up in other states ignored.
REQ-019 SHALL, when buffer holds LAP_DEPTH laps, overwrite the oldest entry; o_lap_cnt saturates at LAP_DEPTH.
REQ-020 SHALL, on i_down in PAUSE or HALT, clear counters, lap buffer, o_lap_cnt and o_view in one cycle; i_down in RUN or IDLE ignored (IDLE also clears laps).
REQ-021 SHALL increment o_view on i_left up to o_lap_cnt and decrement on i_right down to 0; saturate at both ends; simultaneous i_left and i_right ignored.
REQ-022 SHALL keep o_view pointing to the same stored lap is NOT required: after a capture, o_view value is retained and refers to the new k-th most recent lap.
REQ-023 SHALL drive time outputs from live counters when o_view=0, else from the selected lap entry, registered (one-cycle latency from view change).
REQ-024 SHALL prioritise simultaneous buttons: i_set over i_down; i_up processed in same cycle as i_set leaving RUN (capture before stop).
REQ-025 SHALL keep counting and lap storage independent of o_view.

Reset
REQ-026 SHALL, while i_rstn=0 at a rising i_clk edge, enter IDLE with all time outputs 0, o_running=0, o_overflow=0, o_lap_cnt=0, o_view=0, buffer invalidated.
REQ-027 SHALL abandon any in-progress count or capture on reset; no partial state survives.

Verification
REQ-028 Start, 1500 ms pulses, stop -> o_ms=500, o_sec=1, o_running=0, state PAUSE.
REQ-029 WRAP=0, HR_MAX=1, preload via pulses to 1:59:59.999, one more pulse -> outputs hold 1:59:59.999, o_overflow=1; i_down -> all zero, o_overflow=0.
REQ-030 WRAP=1, HR_MAX=1, from 1:59:59.999 one pulse -> 0:00:00.000, o_running=1.
REQ-031 LAP_DEPTH=4, six i_up at 100, 200..600 ms -> o_lap_cnt=4; i_left x4 -> o_view=4, o_ms=300; fifth i_left -> o_view stays 4.
REQ-032 i_up coincident with i_ms_pulse at 41 ms -> stored lap reads 41 ms, live reads 42 ms.
REQ-033 Reset asserted mid-RUN at 3.210 s with 2 laps -> next cycle all outputs zero, o_lap_cnt=0, IDLE.
